serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial add/subtract controller that sequences a single 1-bit full-adder cell over WIDTH cycles, LSB first. It sits beside the ALU as a low-area arithmetic unit. It accepts a start pulse with two operands and a mode bit, shifts one bit pair per clock through the full adder, and reports result, carry, signed overflow and a one-cycle done pulse.

## Interface
- WIDTH, default 4: operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B, 1 = A−B; latched with start.
- a  input  WIDTH  first operand; latched with start.
- b  input  WIDTH  second operand; latched with start.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; result fields valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- cout  output  1  final carry out of the MSB. For sub, 1 means no borrow.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0. Present only with SERIAL_ADD_ZERO_EN.

## Operation
- Reset values: state IDLE; busy, done, cout, overflow and zero = 0; result = 0; internal shift registers, carry and counter = 0.
- Datapath per RUN cycle:
  - Full-adder inputs are opA[0], opB[0] and carry register c.
  - The sum bit shifts into result at the MSB end; opA and opB shift right by one.
  - c takes the new carry.
  - Bit count increments.
- Subtract mode: on accept, opB loads ~b and c loads 1 (two's complement). Add mode: opB loads b and c loads 0.
- Overflow: on the WIDTH-th bit, capture the carry into the MSB before it is overwritten. overflow = that carry XOR cout.
- FSM:
  - IDLE: start=1 → latch operands, clear count → RUN. Otherwise stay in IDLE.
  - RUN: process one bit per cycle. After the bit with count == WIDTH−1 → DONE.
  - DONE: done=1 for this cycle only → IDLE.
- start is ignored in RUN and DONE; no queuing.
- Outputs change only at the RUN→DONE transition. result, cout, overflow and zero keep their last values through IDLE.
- Shift registers are not visible on result during RUN. result updates only at the end of the operation, so a stale result is never corrupted mid-operation.
- Reset asserted mid-operation aborts immediately: all state returns to reset values and no done pulse is issued.

## Timing
- Edge E0 samples start=1 in IDLE. busy is high from E0+ onward.
- Edges E1..EWIDTH each process one bit.
- done is high for exactly the cycle after EWIDTH; busy falls after EWIDTH+1.
- Latency from start edge to done: WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles. The earliest next start is sampled on the edge that returns the FSM to IDLE plus one.
- The counter is $clog2(WIDTH) bits, with no wrap during RUN. Terminal compare is at WIDTH−1.

## Configuration
- SERIAL_ADD_ZERO_EN defined: the zero output port exists. It is registered at RUN→DONE as result == 0, held with result, and reset to 0.
- SERIAL_ADD_ZERO_EN undefined: the zero port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=4, a=3, b=5, sub=0 → done at start+5 cycles; result=4'b1000, cout=0, overflow=1, zero=0.
- a=7, b=2, sub=1 → result=4'b0101, cout=1, overflow=0.
- a=15, b=1, sub=0 → result=0, cout=1, overflow=0, zero=1 (with SERIAL_ADD_ZERO_EN).
- start pulsed again during RUN with a=1, b=1 → ignored; the first operation's result is unchanged and only one done pulse occurs.
- rst_n pulled low at the 2nd RUN cycle → busy=0 and result=0 asynchronously, no done pulse; a fresh start then completes normally.
- Back-to-back: start held high continuously → operations accepted every WIDTH+2 cycles; done pulses are spaced WIDTH+2 apart.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell stepped LSB-first over WIDTH clocks.
// Optional zero-flag output enabled by defining SERIAL_ADD_ZERO_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
`ifdef SERIAL_ADD_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    count;

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] op_a_next;

    // op_a doubles as the sum shift register: sum bits enter at the MSB as operand bits leave the LSB.
    always_comb begin
        sum_bit    = op_a[0] ^ op_b[0] ^ carry;
        carry_next = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
        op_a_next  = {sum_bit, op_a[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry    <= 1'b0;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
`ifdef SERIAL_ADD_ZERO_EN
            zero     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a_next;
                    op_b  <= {1'b0, op_b[WIDTH-1:1]};
                    carry <= carry_next;
                    if (count == LAST) begin
                        // carry still holds the carry into the MSB on this final bit
                        result   <= op_a_next;
                        cout     <= carry_next;
                        overflow <= carry ^ carry_next;
`ifdef SERIAL_ADD_ZERO_EN
                        zero     <= (op_a_next == '0);
`endif
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, corner sequences and random ops vs an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
`ifdef SERIAL_ADD_ZERO_EN
    logic         zero;
`endif

    int total;
    int bad;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
`ifdef SERIAL_ADD_ZERO_EN
        ,
        .zero     (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vsub;
        logic [W-1:0] exp_result;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model from signed/unsigned arithmetic rules
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         output logic [W-1:0] r, output logic c, output logic o);
        int sa;
        int sb;
        int d;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        d  = msub ? (sa - sb) : (sa + sb);
        o  = (d < -(1 << (W - 1))) || (d > ((1 << (W - 1)) - 1));
        if (msub) begin
            r = W'(int'(ma) - int'(mb));
            c = (ma >= mb);
        end else begin
            r = W'(int'(ma) + int'(mb));
            c = ((int'(ma) + int'(mb)) > MAXV);
        end
    endtask

    // One complete operation; latency counts falling edges after the accepting edge until done is seen
    task automatic apply_stimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tsub,
                                  output logic [W-1:0] r, output logic c, output logic o,
                                  output logic z, output int latency, output logic busy_early);
        latency    = 0;
        busy_early = 1'b0;
        @(negedge clk);
        a     = ta;
        b     = tb_;
        sub   = tsub;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start      = 1'b0;
                busy_early = busy;
            end
            if (done) begin
                latency = k;
                break;
            end
        end
        r = result;
        c = cout;
        o = overflow;
`ifdef SERIAL_ADD_ZERO_EN
        z = zero;
`else
        z = 1'b0;
`endif
        @(negedge clk);
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tsub, input logic [W-1:0] er, input logic ec, input logic eo);
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        int           lat;
        logic         be;
        apply_stimulus(ta, tb_, tsub, r, c, o, z, lat, be);
        check_output({tag, " latency"}, lat, W + 1);
        check_output({tag, " busy"}, be, 1);
        check_output({tag, " result"}, r, er);
        check_output({tag, " cout"}, c, ec);
        check_output({tag, " overflow"}, o, eo);
`ifdef SERIAL_ADD_ZERO_EN
        check_output({tag, " zero"}, z, (er == '0));
`endif
        check_output({tag, " idle busy"}, busy, 0);
        check_output({tag, " idle done"}, done, 0);
    endtask

    initial begin
        int           dones;
        int           last_cyc;
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{4'd3,  4'd5, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[1] = '{4'd7,  4'd2, 1'b1, 4'b0101, 1'b1, 1'b0};
        vecs[2] = '{4'd15, 4'd1, 1'b0, 4'd0,    1'b1, 1'b0};
        vecs[3] = '{4'd0,  4'd0, 1'b1, 4'd0,    1'b1, 1'b0};
        vecs[4] = '{4'd8,  4'd1, 1'b1, 4'd7,    1'b1, 1'b1};
        vecs[5] = '{4'd0,  4'd8, 1'b1, 4'd8,    1'b0, 1'b1};
        vecs[6] = '{4'd7,  4'd1, 1'b0, 4'd8,    1'b0, 1'b1};
        vecs[7] = '{4'd15, 4'd15, 1'b0, 4'd14,  1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check_output("reset busy", busy, 0);
        check_output("reset done", done, 0);
        check_output("reset result", result, 0);
        check_output("reset cout", cout, 0);
        check_output("reset overflow", overflow, 0);
`ifdef SERIAL_ADD_ZERO_EN
        check_output("reset zero", zero, 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vsub,
                          vecs[i].exp_result, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // start re-asserted with new operands during RUN must be ignored
        @(negedge clk);
        a = 4'd3; b = 4'd5; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd1; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 3 * W; k++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                check_output("ignored start result", result, 4'b1000);
            end
        end
        check_output("ignored start done count", dones, 1);

        // reset in the second RUN cycle aborts with no done pulse
        @(negedge clk);
        a = 4'd7; b = 4'd2; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort busy", busy, 0);
        check_output("abort result", result, 0);
        check_output("abort done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_output("abort no done", dones, 0);
        run_and_check("after abort", 4'd7, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0);

        // start held high: one operation every W+2 cycles
        @(negedge clk);
        a = 4'd2; b = 4'd3; sub = 1'b0; start = 1'b1;
        dones    = 0;
        last_cyc = 0;
        for (int cyc = 1; cyc <= 4 * (W + 2) + 2; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (dones == 0) check_output("b2b first latency", cyc, W + 1);
                else            check_output("b2b spacing", cyc - last_cyc, W + 2);
                check_output("b2b result", result, 4'd5);
                last_cyc = cyc;
                dones++;
            end
        end
        start = 1'b0;
        check_output("b2b done count", dones, 4);
        repeat (W + 3) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, MAXV));
            rb = W'($urandom_range(0, MAXV));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, er, ec, eo);
            run_and_check($sformatf("rand%0d", i), ra, rb, rs, er, ec, eo);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
